adc_readout_ctrl: RTL and testbench
===================================

Name: adc_readout_ctrl

Overview:
- Digital controller on the near side of the ADC interface. The ADC behavioural model is the far side.
- After a CIM evaluation completes, it steps the ADC mux through all NUM_CH output channels. For each channel it waits for mux settle, asserts the sample strobe, then waits for the converted result.
- Each result is forwarded as a (channel, data) beat on a valid/ready stream toward the neuron/spike-count logic.
- Sits between the CIM-array control FSM and the output neuron block.

Parameters:
- NUM_CH, 10, number of ADC channels scanned; equals NUM_OUTPUTS.
- ADC_BITS, 8, ADC result width.
- SETTLE_CYCLES, 2, mux settle time; equals ADC_MUX_SETTLE_CYCLES; must be ≥1.
- SAMPLE_CYCLES, 3, sample strobe width; equals ADC_SAMPLE_CYCLES; must be ≥1.
- TIMEOUT_CYCLES, 16, maximum wait for adc_data_valid after the strobe ends; must be greater than ADC_LATENCY_CYCLES.
- CH_W, $clog2(NUM_CH), channel index width (4 by default).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle scan request
- abort  in  1  synchronous scan cancel
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at the end of a scan
- err_timeout  out  1  sticky: at least one channel timed out in the current/last scan
- adc_mux_sel  out  CH_W  ADC channel select
- adc_sample  out  1  ADC sample/convert strobe
- adc_data_valid  in  1  ADC result valid, one-cycle pulse
- adc_data  in  ADC_BITS  ADC result
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream ready
- out_ch  out  CH_W  channel of the beat
- out_data  out  ADC_BITS  result of the beat

Behaviour:
- Reset (async, rst_n=0) forces all outputs to 0 and state to IDLE. A reset mid-scan abandons the scan with no done pulse and no further beats.
- FSM states: IDLE, SETTLE, SAMPLE, WAIT_CONV, PUSH, FIN.
- IDLE:
  - busy=0.
  - start=1: ch←0, err_timeout←0, go to SETTLE next cycle.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles; adc_mux_sel=ch; then go to SAMPLE.
- SAMPLE:
  - adc_sample=1 for exactly SAMPLE_CYCLES cycles; then go to WAIT_CONV with the timeout counter cleared.
- WAIT_CONV:
  - On adc_data_valid=1: register adc_data into out_data, out_ch←ch, go to PUSH.
  - If no valid arrives within TIMEOUT_CYCLES cycles: out_data←0, err_timeout←1, go to PUSH.
- PUSH:
  - out_valid=1. out_ch and out_data are held stable until out_ready=1 (AXI-style: valid never drops without ready).
  - On the handshake: if ch==NUM_CH-1 go to FIN, else ch←ch+1 and go to SETTLE.
- FIN:
  - done=1 for one cycle; next state IDLE.
- adc_mux_sel holds ch from SETTLE through PUSH. In IDLE it holds the last value (0 after reset).
- busy=1 in every state except IDLE.
- start while busy is ignored (no restart, no error).
- abort=1 in any non-IDLE state: next state IDLE, out_valid/adc_sample drop immediately, no done pulse. abort has priority over every other transition.
- adc_data_valid outside WAIT_CONV is ignored.
- Nominal per-channel latency with out_ready=1 and ADC latency L: SETTLE_CYCLES + SAMPLE_CYCLES + L + 1 cycles.
- Full scan latency: NUM_CH × that value, plus 1 cycle for FIN, plus 1 cycle for the start-to-SETTLE transition.
- err_timeout is cleared only by reset or the next accepted start.

Test Plan:
- Nominal scan:
  - Stimulus: ADC model returns 8'(ch*7+3) with latency 5; out_ready=1; pulse start.
  - Required: 10 beats, ch 0..9, data 3,10,…,66, in order.
  - Required: adc_sample high for 3 cycles per channel; 11 cycles per channel; done asserted exactly once, 112 cycles after start; err_timeout=0.
- Backpressure:
  - Stimulus: out_ready low for 4 cycles on ch 3.
  - Required: out_valid, out_ch=3 and out_data stay stable for those 4 cycles; no mux advance; scan completes with all 10 beats.
- Timeout:
  - Stimulus: ADC model suppresses valid for ch 5.
  - Required: after 16 wait cycles a beat with ch=5, data=0; err_timeout=1 from then until the next start; channels 6..9 proceed normally.
- Abort:
  - Stimulus: assert abort during SAMPLE of ch 2.
  - Required: next cycle state is IDLE, busy=0, adc_sample=0, no done pulse.
  - Required: a new start then produces a full 10-beat scan.
- Start while busy and spurious valid:
  - Stimulus: start pulses during ch 4; adc_data_valid pulses during SETTLE.
  - Required: the scan is unaffected; beat count is 10; data is uncorrupted.
- Reset mid-scan:
  - Stimulus: drop rst_n during WAIT_CONV of ch 7.
  - Required: all outputs are 0 asynchronously; after release there is no done pulse and no beat until the next start.

Source files
------------

// File: rtl/adc_readout_ctrl.sv
// ADC readout sequencer: scans every ADC channel after a CIM evaluation and
// forwards each (channel, result) pair on a valid/ready stream.
//
// state     | meaning
// IDLE      | waiting for start; adc_mux_sel holds the last channel
// SETTLE    | mux driven to ch, waiting for the analog path to settle
// SAMPLE    | sample/convert strobe high
// WAIT_CONV | waiting for adc_data_valid, bounded by the timeout timer
// PUSH      | result beat presented downstream until accepted
// FIN       | one-cycle done pulse
module adc_readout_ctrl #(
  parameter int NUM_CH         = 10,
  parameter int ADC_BITS       = 8,
  parameter int SETTLE_CYCLES  = 2,
  parameter int SAMPLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CH_W           = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                err_timeout,
  output logic [CH_W-1:0]     adc_mux_sel,
  output logic                adc_sample,
  input  logic                adc_data_valid,
  input  logic [ADC_BITS-1:0] adc_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [ADC_BITS-1:0] out_data
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    WAIT_CONV,
    PUSH,
    FIN
  } state_t;

  localparam int MAX_A   = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int MAX_B   = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int TMR_W   = (MAX_B < 2) ? 1 : $clog2(MAX_B);

  // One shared down-counter times every phase; each phase ends on terminal count zero.
  localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SAMPLE_LD  = TMR_W'(SAMPLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);

  state_t              state, state_nxt;
  logic [CH_W-1:0]     ch, ch_nxt;
  logic [TMR_W-1:0]    tmr, tmr_nxt;
  logic [CH_W-1:0]     out_ch_nxt;
  logic [ADC_BITS-1:0] out_data_nxt;
  logic                err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch          <= '0;
      tmr         <= '0;
      out_ch      <= '0;
      out_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      ch          <= ch_nxt;
      tmr         <= tmr_nxt;
      out_ch      <= out_ch_nxt;
      out_data    <= out_data_nxt;
      err_timeout <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ch_nxt       = ch;
    tmr_nxt      = tmr;
    out_ch_nxt   = out_ch;
    out_data_nxt = out_data;
    err_nxt      = err_timeout;
    if (state != IDLE && abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ch_nxt    = '0;
            err_nxt   = 1'b0;
            tmr_nxt   = SETTLE_LD;
            state_nxt = SETTLE;
          end
        end
        SETTLE: begin
          if (tmr == '0) begin
            tmr_nxt   = SAMPLE_LD;
            state_nxt = SAMPLE;
          end else begin
            tmr_nxt = tmr - 1'b1;
          end
        end
        SAMPLE: begin
          if (tmr == '0) begin
            tmr_nxt   = TIMEOUT_LD;
            state_nxt = WAIT_CONV;
          end else begin
            tmr_nxt = tmr - 1'b1;
          end
        end
        WAIT_CONV: begin
          // A result arriving on the last wait cycle still wins over the timeout.
          if (adc_data_valid) begin
            out_data_nxt = adc_data;
            out_ch_nxt   = ch;
            state_nxt    = PUSH;
          end else if (tmr == '0) begin
            out_data_nxt = '0;
            out_ch_nxt   = ch;
            err_nxt      = 1'b1;
            state_nxt    = PUSH;
          end else begin
            tmr_nxt = tmr - 1'b1;
          end
        end
        PUSH: begin
          if (out_ready) begin
            if (ch == LAST_CH) begin
              state_nxt = FIN;
            end else begin
              ch_nxt    = ch + 1'b1;
              tmr_nxt   = SETTLE_LD;
              state_nxt = SETTLE;
            end
          end
        end
        FIN:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // abort masks the strobes in the same cycle so nothing leaks out while unwinding.
  assign busy        = (state != IDLE);
  assign adc_mux_sel = ch;
  assign adc_sample  = (state == SAMPLE) && !abort;
  assign out_valid   = (state == PUSH) && !abort;
  assign done        = (state == FIN) && !abort;

endmodule

// File: tb/tb_adc_readout_ctrl.sv
// Scoreboard bench for adc_readout_ctrl: expected beats are queued at each
// start and popped on every out_valid/out_ready handshake.
module tb_adc_readout_ctrl;

  localparam int NUM_CH  = 10;
  localparam int ADC_LAT = 5;

  typedef struct {
    int ch;
    int data;
    bit tmo;
    int gap;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       err_timeout;
  logic [3:0] adc_mux_sel;
  logic       adc_sample;
  logic       adc_data_valid = 1'b0;
  logic [7:0] adc_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_ch;
  logic [7:0] out_data;

  int    n_chk = 0;
  int    n_err = 0;
  int    cyc = 0;
  beat_t sb[$];
  int    beat_cnt = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    st_cyc = 0;
  int    last_hs = 0;
  int    smp_run = 0;
  bit    exp_err = 1'b0;
  bit    chk_gap = 1'b1;
  bit    stall_arm = 1'b0;
  int    stall_left = 0;
  int    suppress_ch = -1;
  bit    spur_en = 1'b0;
  int    lat_cnt = 0;
  logic  prev_smp = 1'b0;
  logic [3:0] prev_mux = 4'd0;

  adc_readout_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .err_timeout    (err_timeout),
    .adc_mux_sel    (adc_mux_sel),
    .adc_sample     (adc_sample),
    .adc_data_valid (adc_data_valid),
    .adc_data       (adc_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ch         (out_ch),
    .out_data       (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ADC far side: result = ch*7+3, ADC_LAT cycles after the strobe falls.
  always @(negedge clk) begin
    adc_data_valid = 1'b0;
    if (!rst_n) begin
      lat_cnt  = 0;
      prev_smp = 1'b0;
      prev_mux = 4'd0;
    end else begin
      if (prev_smp && !adc_sample) lat_cnt = 1;
      else if (lat_cnt > 0) lat_cnt++;
      if (lat_cnt == ADC_LAT) begin
        lat_cnt = 0;
        if (int'(adc_mux_sel) != suppress_ch) begin
          adc_data_valid = 1'b1;
          adc_data       = 8'(int'(adc_mux_sel) * 7 + 3);
        end
      end else if (spur_en && adc_mux_sel != prev_mux) begin
        adc_data_valid = 1'b1;
        adc_data       = 8'hEE;
      end
      prev_smp = adc_sample;
      prev_mux = adc_mux_sel;
    end
  end

  // Downstream sink and scoreboard compare.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      smp_run    = 0;
      out_ready  = 1'b1;
      stall_left = 0;
    end else begin
      if (stall_arm && out_valid && int'(out_ch) == 3) begin
        stall_arm  = 1'b0;
        stall_left = 4;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        if (stall_left < 3) begin
          chk("bp_valid", int'(out_valid), 1);
          chk("bp_ch", int'(out_ch), 3);
          chk("bp_data", int'(out_data), 24);
          chk("bp_mux", int'(adc_mux_sel), 3);
        end
      end else begin
        out_ready = 1'b1;
      end
      if (adc_sample) smp_run++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (sb.size() == 0) begin
          chk("beat_unexpected_ch", int'(out_ch), -1);
        end else begin
          e = sb.pop_front();
          if (e.tmo) exp_err = 1'b1;
          chk("beat_ch", int'(out_ch), e.ch);
          chk("beat_data", int'(out_data), e.data);
          chk("beat_err_timeout", int'(err_timeout), int'(exp_err));
          chk("sample_len", smp_run, 3);
          if (chk_gap) chk("ch_period", cyc - last_hs, e.gap);
        end
        last_hs = cyc;
        smp_run = 0;
      end
    end
  end

  task automatic do_start(int sup);
    beat_t e;
    for (int c = 0; c < NUM_CH; c++) begin
      e.ch   = c;
      e.tmo  = (c == sup);
      e.data = e.tmo ? 0 : ((c * 7 + 3) % 256);
      e.gap  = e.tmo ? 22 : 11;
      sb.push_back(e);
    end
    suppress_ch = sup;
    exp_err     = 1'b0;
    beat_cnt    = 0;
    done_cnt    = 0;
    smp_run     = 0;
    @(posedge clk);
    #1;
    start   = 1'b1;
    st_cyc  = cyc;
    last_hs = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_scan_check(string nm, int lat);
    int k = 0;
    while (done_cnt == 0 && k < 400) begin
      tick();
      k++;
    end
    chk({nm, "_done"}, done_cnt, 1);
    chk({nm, "_latency"}, done_cyc + 1 - st_cyc, lat);
    repeat (5) tick();
    chk({nm, "_done_once"}, done_cnt, 1);
    chk({nm, "_beats"}, beat_cnt, NUM_CH);
    chk({nm, "_sb_left"}, sb.size(), 0);
    chk({nm, "_busy"}, int'(busy), 0);
  endtask

  task automatic wait_sample_ch(int c);
    int k = 0;
    while (!(adc_sample && int'(adc_mux_sel) == c) && k < 300) begin
      tick();
      k++;
    end
    chk("reach_sample_ch", int'(adc_sample && int'(adc_mux_sel) == c), 1);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err_timeout), 0);
    chk("rst_mux", int'(adc_mux_sel), 0);
    chk("rst_sample", int'(adc_sample), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_data", int'(out_data), 0);
    rst_n = 1'b1;
    repeat (3) tick();

    do_start(-1);
    run_scan_check("nominal", 112);
    chk("nominal_err", int'(err_timeout), 0);

    chk_gap   = 1'b0;
    stall_arm = 1'b1;
    do_start(-1);
    run_scan_check("backpressure", 116);
    chk_gap = 1'b1;

    do_start(5);
    run_scan_check("timeout", 123);
    repeat (10) tick();
    chk("timeout_err_sticky", int'(err_timeout), 1);

    do_start(-1);
    tick();
    chk("start_clears_err", int'(err_timeout), 0);
    wait_sample_ch(2);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_sample", int'(adc_sample), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    repeat (20) tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_beats", beat_cnt, 2);
    sb.delete();
    do_start(-1);
    run_scan_check("abort_rescan", 112);

    spur_en = 1'b1;
    do_start(-1);
    wait_sample_ch(4);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    run_scan_check("busy_start_spur", 112);
    spur_en = 1'b0;

    do_start(-1);
    wait_sample_ch(7);
    k = 0;
    while (adc_sample && k < 20) begin
      tick();
      k++;
    end
    chk("reach_wait_conv", int'(adc_sample), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_err", int'(err_timeout), 0);
    chk("arst_mux", int'(adc_mux_sel), 0);
    chk("arst_sample", int'(adc_sample), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_ch", int'(out_ch), 0);
    chk("arst_out_data", int'(out_data), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    beat_cnt = 0;
    done_cnt = 0;
    repeat (30) tick();
    chk("post_rst_beats", beat_cnt, 0);
    chk("post_rst_done", done_cnt, 0);
    chk("post_rst_busy", int'(busy), 0);
    do_start(-1);
    run_scan_check("post_rst_scan", 112);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
